// File: rtl/serial_pattern_tx_if.sv
// Start/operand handshake and serial output bundle for serial_pattern_tx.
// The master drives the request; the slave (the transmitter) drives the stream.
interface serial_pattern_tx_if #(
  parameter int W = 8
);
  localparam int LW = $clog2(W) + 1;

  logic          start;
  logic [W-1:0]  pattern;
  logic [LW-1:0] len;
  logic [3:0]    reps;
  logic          data;
  logic          data_vld;
  logic          busy;
  logic          done;

  modport master (
    output start, pattern, len, reps,
    input  data, data_vld, busy, done
  );

  modport slave (
    input  start, pattern, len, reps,
    output data, data_vld, busy, done
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// Repeating MSB-first serialiser: sends len bits of a captured pattern reps times,
// with GAP idle cycles between repetitions, then pulses done.
module serial_pattern_tx #(
  parameter int W   = 8,
  parameter int GAP = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_pattern_tx_if.slave bus
);
  localparam int            LW       = $clog2(W) + 1;
  localparam logic [LW-1:0] W_L      = LW'(W);
  localparam logic [LW-1:0] ONE_L    = LW'(1);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    SHIFT    = 4'b0010,
    GAP_WAIT = 4'b0100,
    FIN      = 4'b1000
  } state_t;

  state_t        state_reg, state_next;
  logic [W-1:0]  pat_reg, pat_next;
  logic [LW-1:0] len_reg, len_next;
  logic [LW-1:0] bit_reg, bit_next;
  logic [3:0]    rep_reg, rep_next;
  logic [3:0]    gap_reg, gap_next;
  logic          data_reg, data_next;
  logic          vld_reg, vld_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          cur_bit;
  logic          start_ok;

  assign cur_bit = |(pat_reg & (W'(1) << bit_reg));

  // The cycle showing done=1 is the FIN cycle seen from outside, so a start
  // there is refused; the following idle cycle accepts normally.
  assign start_ok = bus.start && !done_reg &&
                    (bus.len != '0) && (bus.len <= W_L);

  always_comb begin
    state_next = state_reg;
    pat_next   = pat_reg;
    len_next   = len_reg;
    bit_next   = bit_reg;
    rep_next   = rep_reg;
    gap_next   = gap_reg;
    data_next  = 1'b0;
    vld_next   = 1'b0;
    busy_next  = 1'b1;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        busy_next = 1'b0;
        if (start_ok) begin
          pat_next   = bus.pattern;
          len_next   = bus.len;
          bit_next   = bus.len - ONE_L;
          rep_next   = (bus.reps == 4'd0) ? 4'd1 : bus.reps;
          busy_next  = 1'b1;
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        data_next = cur_bit;
        vld_next  = 1'b1;
        if (bit_reg == '0) begin
          if (rep_reg > 4'd1) begin
            rep_next = rep_reg - 4'd1;
            bit_next = len_reg - ONE_L;
            if (GAP == 0) begin
              state_next = SHIFT;
            end else begin
              gap_next   = GAP_LAST;
              state_next = GAP_WAIT;
            end
          end else begin
            state_next = FIN;
          end
        end else begin
          bit_next = bit_reg - ONE_L;
        end
      end

      GAP_WAIT: begin
        if (gap_reg == 4'd0) begin
          state_next = SHIFT;
        end else begin
          gap_next = gap_reg - 4'd1;
        end
      end

      FIN: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end

      default: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pat_reg   <= '0;
      len_reg   <= '0;
      bit_reg   <= '0;
      rep_reg   <= '0;
      gap_reg   <= '0;
      data_reg  <= 1'b0;
      vld_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pat_reg   <= pat_next;
      len_reg   <= len_next;
      bit_reg   <= bit_next;
      rep_reg   <= rep_next;
      gap_reg   <= gap_next;
      data_reg  <= data_next;
      vld_reg   <= vld_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign bus.data     = data_reg;
  assign bus.data_vld = vld_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: GAP=2 and GAP=0 instances checked cycle by cycle
// against an expected stream built from pattern/len/reps/GAP.
module tb_serial_pattern_tx;
  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_pattern_tx_if #(.W(W)) bus_g2 ();
  serial_pattern_tx_if #(.W(W)) bus_g0 ();

  serial_pattern_tx #(.W(W), .GAP(2)) dut_g2 (.clk(clk), .rst_n(rst_n), .bus(bus_g2));
  serial_pattern_tx #(.W(W), .GAP(0)) dut_g0 (.clk(clk), .rst_n(rst_n), .bus(bus_g0));

  logic         start   = 1'b0;
  logic [W-1:0] pattern = '0;
  logic [3:0]   len     = '0;
  logic [3:0]   reps    = '0;
  logic         sel     = 1'b0;  // 0: GAP=2 instance, 1: GAP=0 instance

  assign bus_g2.start   = start & ~sel;
  assign bus_g0.start   = start & sel;
  assign bus_g2.pattern = pattern;
  assign bus_g0.pattern = pattern;
  assign bus_g2.len     = len;
  assign bus_g0.len     = len;
  assign bus_g2.reps    = reps;
  assign bus_g0.reps    = reps;

  logic [3:0] obs;  // {busy, data_vld, data, done} of the selected instance
  assign obs = sel ? {bus_g0.busy, bus_g0.data_vld, bus_g0.data, bus_g0.done}
                   : {bus_g2.busy, bus_g2.data_vld, bus_g2.data, bus_g2.done};

  int vectors     = 0;
  int miscompares = 0;

  task automatic scramble();
    pattern = W'($urandom);
    len     = 4'($urandom_range(0, 15));
    reps    = 4'($urandom_range(0, 15));
  endtask

  // One full transmission; returns the count of 101 windows in the valid bits.
  task automatic run_tx(input logic s, input logic [W-1:0] p, input int l, input int r,
                        input int glitch, input bit start_in_done, output int det);
    logic [1:0] exp_q[$];
    int nreps;
    int gap;
    logic [2:0] win;
    nreps = (r == 0) ? 1 : r;
    gap   = s ? 0 : 2;
    for (int k = 0; k < nreps; k++) begin
      for (int b = l - 1; b >= 0; b--) exp_q.push_back({1'b1, p[b]});
      if (k < nreps - 1)
        for (int g = 0; g < gap; g++) exp_q.push_back(2'b00);
    end

    sel = s; pattern = p; len = 4'(l); reps = 4'(r); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
    vectors++;
    if (obs !== 4'b1000) begin
      miscompares++;
      $display("FAIL accept: got %b expected 1000", obs);
    end

    win = 3'b000;
    det = 0;
    foreach (exp_q[i]) begin
      if (i == glitch) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      scramble();
      vectors++;
      if (obs !== {1'b1, exp_q[i], 1'b0}) begin
        miscompares++;
        $display("FAIL stream[%0d]: got %b expected %b", i, obs, {1'b1, exp_q[i], 1'b0});
      end
      if (obs[2] === 1'b1) begin
        win = {win[1:0], obs[1]};
        if (win == 3'b101) det++;
      end
    end

    @(negedge clk);
    vectors++;
    if (obs !== 4'b1001) begin
      miscompares++;
      $display("FAIL done: got %b expected 1001", obs);
    end
    if (start_in_done) begin
      start   = 1'b1;
      pattern = W'($urandom);
      len     = 4'($urandom_range(1, W));
      reps    = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    vectors++;
    if (obs !== 4'b0000) begin
      miscompares++;
      $display("FAIL after_done: got %b expected 0000", obs);
    end
    $display("tx gap=%0d pattern=%h len=%0d reps=%0d cycles=%0d det101=%0d",
             gap, p, l, r, exp_q.size() + 1, det);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; pattern = 8'hA5; len = 4'd4; reps = 4'd2;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      vectors++;
      if (obs !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_state sel=%0d: got %b expected 0000", s, obs);
      end
    end
    start = 1'b0; sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs !== 4'b0000) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %b expected 0000", obs);
    end
  endtask

  task automatic test_bad_len();
    sel = 1'b0;
    for (int t = 0; t < 2; t++) begin
      pattern = W'($urandom);
      len     = (t == 0) ? 4'd0 : 4'($urandom_range(W + 1, 15));
      reps    = 4'($urandom_range(1, 15));
      start   = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        vectors++;
        if (obs !== 4'b0000) begin
          miscompares++;
          $display("FAIL bad_len len=%0d cycle %0d: got %b expected 0000", len, c, obs);
        end
      end
      start = 1'b0;
      $display("tx bad len=%0d held 10 cycles", len);
    end
  endtask

  task automatic test_fixed();
    int det;
    run_tx(1'b0, 8'h05, 3, 1, -1, 1'b0, det);
    vectors++;
    if (det !== 1) begin
      miscompares++;
      $display("FAIL det_single: got %0d expected 1", det);
    end
    run_tx(1'b0, 8'h05, 3, 2, -1, 1'b0, det);
    vectors++;
    if (det !== 2) begin
      miscompares++;
      $display("FAIL det_double: got %0d expected 2", det);
    end
    run_tx(1'b0, 8'hA5, 8, 1, 2, 1'b0, det);
  endtask

  task automatic test_reset_mid();
    int det;
    sel = 1'b0; pattern = 8'hFF; len = 4'd8; reps = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (obs !== 4'b1110) begin
      miscompares++;
      $display("FAIL fifth_bit: got %b expected 1110", obs);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (obs !== 4'b0000) begin
      miscompares++;
      $display("FAIL async_reset: got %b expected 0000", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      vectors++;
      if (obs !== 4'b0000) begin
        miscompares++;
        $display("FAIL abandoned cycle %0d: got %b expected 0000", c, obs);
      end
    end
    $display("tx reset mid-shift, abandoned");
    run_tx(1'b0, 8'h03, 2, 1, -1, 1'b0, det);
  endtask

  task automatic test_gap0();
    int det;
    run_tx(1'b1, 8'h02, 2, 3, -1, 1'b0, det);
  endtask

  task automatic test_back_to_back();
    int det;
    run_tx(1'b0, 8'h96, 5, 2, -1, 1'b1, det);
    run_tx(1'b0, 8'h5A, 4, 1, -1, 1'b1, det);
    run_tx(1'b1, 8'hC3, 6, 2, -1, 1'b0, det);
  endtask

  task automatic test_random();
    int det;
    for (int n = 0; n < 30; n++) begin
      run_tx(1'($urandom_range(0, 1)), W'($urandom), $urandom_range(1, W),
             $urandom_range(0, 15), $urandom_range(0, 12), 1'($urandom_range(0, 1)), det);
    end
  endtask

  initial begin
    test_reset();
    test_bad_len();
    test_fixed();
    test_reset_mid();
    test_gap0();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/serial_pattern_tx.md
SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 Parameter W, default 8, maximum pattern width in bits (legal range 2..16).
REQ-002 Parameter GAP, default 2, idle cycles inserted between repetitions (legal range 0..15).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  request to begin a transmission; sampled only in IDLE.
REQ-006 pattern  input  W  bit pattern; bit len-1 is sent first, bit 0 last.
REQ-007 len  input  $clog2(W)+1  number of pattern bits to send per repetition.
REQ-008 reps  input  4  number of repetitions.
REQ-009 data  output  1  serial bit stream, registered.
REQ-010 data_vld  output  1  high when data carries a valid pattern bit, registered.
REQ-011 busy  output  1  high from the cycle after start is accepted until done has been asserted, registered.
REQ-012 done  output  1  single-cycle completion pulse, registered.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT, GAP_WAIT and FIN, one-hot encoded; any illegal encoding SHALL return to IDLE on the next edge.
REQ-014 In IDLE with start=1 and 1<=len<=W, the block SHALL capture pattern, len and reps (reps=0 treated as 1) and enter SHIFT on the same edge.
REQ-015 start with len=0 or len>W SHALL be ignored: the block stays in IDLE and all outputs stay 0.
REQ-016 start SHALL be ignored in any state other than IDLE; captured operands SHALL NOT change mid-transmission.
REQ-017 Latency: if start is accepted at edge k, data_vld=1 and data=pattern[len-1] SHALL be visible after edge k+1.
REQ-018 In SHIFT the block SHALL emit one bit per cycle, MSB-first from bit len-1 down to bit 0, for exactly len consecutive cycles with data_vld=1.
REQ-019 After the last bit, if repetitions remain, the FSM SHALL enter GAP_WAIT for exactly GAP cycles (data=0, data_vld=0), then re-enter SHIFT with the captured pattern.
REQ-020 With GAP=0, repetitions SHALL be back-to-back with no data_vld=0 cycle between them.
REQ-021 After the final repetition the FSM SHALL enter FIN for one cycle: done=1, data_vld=0, data=0, busy=1; it then enters IDLE with busy=0.
REQ-022 A start asserted during the FIN cycle SHALL be ignored; a start in the first IDLE cycle after FIN SHALL be accepted.
REQ-023 Whenever data_vld=0, data SHALL be 0.
REQ-024 Bit counter SHALL be $clog2(W)+1 bits wide; repetition counter SHALL be 4 bits wide; neither counter SHALL wrap during legal operation.
REQ-025 Total cycles from acceptance to done, inclusive of done, SHALL be reps*len + (reps-1)*GAP + 1.

Reset
REQ-026 On rst_n=0, the block SHALL immediately enter IDLE and force data, data_vld, busy and done to 0, and clear all counters and captured operands.
REQ-027 If reset is asserted mid-SHIFT or mid-GAP_WAIT, the transmission SHALL be abandoned without a done pulse; after release the block SHALL accept a new start normally.

Verification
REQ-028 W=8, GAP=2: pattern=8'h05, len=3, reps=1 -> data 1,0,1 with data_vld=1 on three consecutive cycles starting at k+1; done=1 at k+4; busy=0 at k+5.
REQ-029 pattern=8'h05, len=3, reps=2 -> data_vld sequence 1,1,1,0,0,1,1,1 with bits 101 00 101, then done; a downstream 101 detector flags twice.
REQ-030 pattern=8'hA5, len=8, reps=1 -> bits 1,0,1,0,0,1,0,1; done at k+9; start pulsed at k+3 is ignored.
REQ-031 len=0, start=1 -> no state change: busy, data_vld and done all stay 0 for 10 cycles.
REQ-032 pattern=8'hFF, len=8, reps=3, rst_n pulsed low during the 5th bit -> outputs 0 within the reset cycle and no done; a subsequent start with pattern=8'h03, len=2, reps=1 -> bits 1,1 then done.
REQ-033 GAP=0 build: pattern=8'h02, len=2, reps=3 -> data 1,0,1,0,1,0 with data_vld continuously 1 for 6 cycles, then done.
